// File: rtl/code_converter_pkg.sv
// Shared types and constants for the nibble code converter.
package code_converter_pkg;
  localparam logic [1:0] MODE_BCD2XS3  = 2'b00;
  localparam logic [1:0] MODE_XS32BCD  = 2'b01;
  localparam logic [1:0] MODE_BIN2GRAY = 2'b10;
  localparam logic [1:0] MODE_NINES    = 2'b11;

  typedef logic [3:0] nibble_t;

  localparam nibble_t ILLEGAL_RESULT = 4'b0000;

  typedef struct packed {
    nibble_t res;
    logic    err;
  } conv_rsp_t;
endpackage

// File: rtl/code_converter_core.sv
// Combinational conversion table: nibble + mode -> result and illegal-code flag.
module code_converter_core
  import code_converter_pkg::*;
(
  input  nibble_t    nib,
  input  logic [1:0] mode,
  output conv_rsp_t  rsp
);
  // Illegal is the default; each mode clears err only inside its legal range.
  always_comb begin
    rsp = '{res: ILLEGAL_RESULT, err: 1'b1};
    case (mode)
      MODE_BCD2XS3: if (nib <= 4'd9) begin
        rsp.res = nib + 4'd3;
        rsp.err = 1'b0;
      end
      MODE_XS32BCD: if (nib >= 4'd3 && nib <= 4'd12) begin
        rsp.res = nib - 4'd3;
        rsp.err = 1'b0;
      end
      MODE_BIN2GRAY: begin
        rsp.res = nib ^ (nib >> 1);
        rsp.err = 1'b0;
      end
      MODE_NINES: if (nib <= 4'd9) begin
        rsp.res = 4'd9 - nib;
        rsp.err = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/code_converter.sv
// Registered 4-bit code converter with loadable mode and same-cycle mode bypass.
module code_converter
  import code_converter_pkg::*;
#(
  parameter logic [1:0] RESET_MODE = MODE_BCD2XS3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic       mode_load,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       w,
  output logic       out_valid,
  output logic       err
);
  localparam int STAGES = 1;

  logic [1:0]    mode_q;
  logic [1:0]    mode_eff;
  nibble_t       res_q;
  logic          err_q;
  logic [STAGES:0] vld_pipe;
  conv_rsp_t     rsp;

  // A mode written this cycle applies to the sample taken on the same edge.
  assign mode_eff    = mode_load ? mode : mode_q;
  assign vld_pipe[0] = in_valid;

  code_converter_core u_core (
    .nib  ({a, b, c, d}),
    .mode (mode_eff),
    .rsp  (rsp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q                 <= RESET_MODE;
      res_q                  <= ILLEGAL_RESULT;
      err_q                  <= 1'b0;
      vld_pipe[STAGES:1]     <= '0;
    end else begin
      if (mode_load) mode_q <= mode;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (in_valid) begin
        res_q <= rsp.res;
        err_q <= rsp.err;
      end
    end
  end

  assign {x, y, z, w} = res_q;
  assign err          = err_q;
  assign out_valid    = vld_pipe[STAGES];
endmodule

// File: tb/tb_code_converter.sv
// Directed test of code_converter: each task drives vectors and checks hand-computed results.
module tb_code_converter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c, d;
  logic       in_valid;
  logic [1:0] mode;
  logic       mode_load;
  logic       x, y, z, w;
  logic       out_valid;
  logic       err;

  int total = 0;
  int bad   = 0;

  code_converter #(.RESET_MODE(2'b00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .mode      (mode),
    .mode_load (mode_load),
    .x         (x),
    .y         (y),
    .z         (z),
    .w         (w),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Drive on the falling edge, then settle just past the following rising edge.
  task automatic drv(input logic [3:0] n, input logic v, input logic ml, input logic [1:0] md);
    @(negedge clk);
    {a, b, c, d} = n;
    in_valid     = v;
    mode_load    = ml;
    mode         = md;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++;
    if ({x, y, z, w} !== 4'b0000 || err !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: got r=%b err=%b ov=%b want r=0000 err=0 ov=0", {x, y, z, w}, err, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Load gray mode with a valid sample so the outputs are non-zero before the mid-stream reset.
    drv(4'b0111, 1'b1, 1'b1, 2'b10);
    total++;
    if ({x, y, z, w} !== 4'b0100 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre: got r=%b ov=%b want r=0100 ov=1", {x, y, z, w}, out_valid);
    end
    drv(4'b1000, 1'b1, 1'b0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({x, y, z, w} !== 4'b0000 || err !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got r=%b err=%b ov=%b want r=0000 err=0 ov=0", {x, y, z, w}, err, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drv(4'd5, 1'b1, 1'b0, 2'b10);
    total++;
    if ({x, y, z, w} !== 4'b1000 || err !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mode: got r=%b err=%b ov=%b want r=1000 err=0 ov=1", {x, y, z, w}, err, out_valid);
    end
  endtask

  task automatic test_bcd2xs3;
    logic [3:0] exp_r [16] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12,
                               4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       exp_e [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    for (int n = 0; n < 16; n++) begin
      // Before the edge the previous result must still be showing.
      @(negedge clk);
      {a, b, c, d} = 4'(n);
      in_valid = 1'b1; mode_load = 1'b0; mode = 2'b00;
      if (n > 0) begin
        total++;
        if ({x, y, z, w} !== exp_r[n-1]) begin
          bad++;
          $display("FAIL xs3_latency n=%0d: got r=%b want %b", n, {x, y, z, w}, exp_r[n-1]);
        end
      end
      @(posedge clk);
      #1;
      total++;
      if ({x, y, z, w} !== exp_r[n] || err !== exp_e[n] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL xs3 n=%0d: got r=%b err=%b ov=%b want r=%b err=%b ov=1",
                 n, {x, y, z, w}, err, out_valid, exp_r[n], exp_e[n]);
      end
    end
  endtask

  task automatic test_xs32bcd;
    logic [3:0] vin   [5] = '{4'b0011, 4'b1100, 4'b0001, 4'b1101, 4'b0111};
    logic [3:0] exp_r [5] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0100};
    logic       exp_e [5] = '{0, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      drv(vin[i], 1'b1, (i == 0), 2'b01);
      total++;
      if ({x, y, z, w} !== exp_r[i] || err !== exp_e[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL xs32bcd in=%b: got r=%b err=%b want r=%b err=%b",
                 vin[i], {x, y, z, w}, err, exp_r[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_gray;
    logic [3:0] vin   [5] = '{4'b0000, 4'b0111, 4'b1000, 4'b1111, 4'b1010};
    logic [3:0] exp_r [5] = '{4'b0000, 4'b0100, 4'b1100, 4'b1000, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      drv(vin[i], 1'b1, (i == 0), 2'b10);
      total++;
      if ({x, y, z, w} !== exp_r[i] || err !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL gray in=%b: got r=%b err=%b want r=%b err=0",
                 vin[i], {x, y, z, w}, err, exp_r[i]);
      end
    end
  endtask

  task automatic test_nines;
    logic [3:0] vin   [5] = '{4'd0, 4'd4, 4'd9, 4'b1011, 4'd7};
    logic [3:0] exp_r [5] = '{4'b1001, 4'b0101, 4'b0000, 4'b0000, 4'b0010};
    logic       exp_e [5] = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      drv(vin[i], 1'b1, (i == 0), 2'b11);
      total++;
      if ({x, y, z, w} !== exp_r[i] || err !== exp_e[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL nines in=%b: got r=%b err=%b want r=%b err=%b",
                 vin[i], {x, y, z, w}, err, exp_r[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_hold_bypass;
    // Last result in mode 11 was 9-7 = 0010, err 0.
    for (int i = 0; i < 3; i++) begin
      drv(4'b1110, 1'b0, 1'b0, 2'b00);
      total++;
      if ({x, y, z, w} !== 4'b0010 || err !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold cyc=%0d: got r=%b err=%b ov=%b want r=0010 err=0 ov=0",
                 i, {x, y, z, w}, err, out_valid);
      end
    end
    drv(4'b0110, 1'b1, 1'b1, 2'b10);
    total++;
    if ({x, y, z, w} !== 4'b0101 || err !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bypass: got r=%b err=%b ov=%b want r=0101 err=0 ov=1", {x, y, z, w}, err, out_valid);
    end
    // Mode register keeps gray; mode input is ignored without mode_load.
    drv(4'b0011, 1'b1, 1'b0, 2'b00);
    total++;
    if ({x, y, z, w} !== 4'b0010 || err !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mode_keep: got r=%b err=%b want r=0010 err=0", {x, y, z, w}, err);
    end
    drv(4'b0011, 1'b0, 1'b0, 2'b00);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ov_pulse: got ov=%b want 0", out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {a, b, c, d} = 4'b0000;
    in_valid = 1'b0;
    mode_load = 1'b0;
    mode = 2'b00;
    #12;
    test_reset;
    test_bcd2xs3;
    test_xs32bcd;
    test_gray;
    test_nines;
    test_hold_bypass;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/code_converter.md
# code_converter

Registered 4-bit code converter that translates a nibble presented on `a`,`b`,`c`,`d` into a selected target code on `x`,`y`,`z`,`w`. It supports BCD→Excess-3 (the default conversion), Excess-3→BCD, binary→Gray and BCD 9's complement, and flags input codes that are illegal for the selected conversion. It sits between a nibble source (switches or an upstream datapath) and a display or decode stage, with one-cycle registered latency.

## Interface
Parameters:
- `RESET_MODE`, default 2'b00: conversion mode loaded into the mode register on reset (BCD→Excess-3).

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a`  input  1  input code bit 3 (MSB, weight 8).
- `b`  input  1  input code bit 2 (weight 4).
- `c`  input  1  input code bit 1 (weight 2).
- `d`  input  1  input code bit 0 (LSB, weight 1).
- `in_valid`  input  1  qualifies `a..d`; sampled on each rising edge.
- `mode`  input  2  00 BCD→XS3, 01 XS3→BCD, 10 binary→Gray, 11 BCD 9's complement.
- `mode_load`  input  1  when high, `mode` is captured into the mode register on the rising edge.
- `x`  output  1  result bit 3 (MSB).
- `y`  output  1  result bit 2.
- `z`  output  1  result bit 1.
- `w`  output  1  result bit 0 (LSB).
- `out_valid`  output  1  high for one cycle per accepted input.
- `err`  output  1  input was illegal for the active mode; qualified by `out_valid`.

## Operation
- Input nibble N = {a,b,c,d}. Result R = {x,y,z,w}.
- Mode 00, BCD→XS3: N in 0..9 gives R = N+3; N in 10..15 is illegal.
- Mode 01, XS3→BCD: N in 3..12 gives R = N−3; N in 0..2 and 13..15 are illegal.
- Mode 10, binary→Gray: R = N ^ (N>>1). All 16 inputs are legal.
- Mode 11, 9's complement: N in 0..9 gives R = 9−N; N in 10..15 is illegal.
- Illegal input: R = 4'b0000 and `err` = 1. Legal input: `err` = 0.
- Mode register: updated only when `mode_load` is high. When `mode_load` and `in_valid` are high in the same cycle, the new `mode` is applied to that same sample (a mode bypass).
- When `in_valid` is low, R and `err` hold their last values and `out_valid` = 0.

## Timing
- Latency: 1 clock. Inputs sampled on edge k appear on R, `err` and `out_valid` after edge k.
- Throughput: one conversion per clock with no back-pressure.
- Reset (`rst_n` low, asynchronous): R = 0000, `err` = 0, `out_valid` = 0, mode register = `RESET_MODE`. Reset takes effect immediately, including mid-stream.
- First edge after `rst_n` rises: normal sampling.
- No combinational path from inputs to outputs. All outputs come directly from flops.

## Structure
- Shared package `code_converter_pkg` holds:
  - Mode localparams: `MODE_BCD2XS3`, `MODE_XS32BCD`, `MODE_BIN2GRAY`, `MODE_NINES`.
  - The 4-bit nibble typedef.
  - The constant `ILLEGAL_RESULT` = 4'b0000.
- One combinational sub-module `code_converter_core`:
  - Inputs: nibble and mode.
  - Outputs: result and `err`.
  - Implemented as a case table.
- The top level instantiates `code_converter_core` and adds the mode register, the bypass mux and the output registers.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → R = 0000, `err`=0 and `out_valid`=0 immediately; after release, the mode is BCD→XS3.
- Mode 00 exhaustive sweep of N=0..15:
  - 0→0011, 5→1000, 9→1100, all with `err`=0.
  - 10..15 → R = 0000 with `err`=1.
  - Each result appears one clock after its input.
- Mode 01:
  - 0011→0000 and 1100→1001, both with `err`=0.
  - 0001 and 1101 → R = 0000 with `err`=1.
- Mode 10 sweep: 0000→0000, 0111→0100, 1000→1100, 1111→1000, all with `err`=0.
- Mode 11: 0→1001, 4→0101, 9→0000 (legal); 1011 → `err`=1.
- Hold and bypass:
  - `in_valid`=0 for 3 cycles → R unchanged and `out_valid`=0.
  - `mode_load`=1 with `mode`=10 together with N=0110 and `in_valid`=1 → next cycle R = 0101 (the new mode is used for that sample).
